// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// funct3 width/sign codes, the access FSM state type and byte-enable generation.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Byte enables for a word-aligned bus.
  // Byte and half codes are matched explicitly.
  // Every other funct3 value (including 011/110/111) is treated as word width.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_LB, F3_LBU: be = 4'b0001 << addr_lo;
      F3_LH, F3_LHU: be = 4'b0011 << {addr_lo[1], 1'b0};
      default:       be = 4'hF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_ext.sv
// Load data extraction: picks the byte/half lane addressed by the latched
// offset out of the full bus word, then sign- or zero-extends it.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = rdata[{offset, 3'b000} +: 8];
  assign half_val = rdata[{offset[1], 4'b0000} +: 16];

  // Select width and extension; funct3[2] set means unsigned.
  always_comb begin
    ext_data = rdata;
    case (funct3[1:0])
      2'b00:   ext_data = funct3[2] ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
      2'b01:   ext_data = funct3[2] ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Turns the M-stage access into a single
// valid/ready bus transaction, stalls the pipeline until it finishes and
// suppresses misaligned accesses.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [XLEN-1:0] alu_out_m,
  input  logic [XLEN-1:0] memwdata_m,
  input  logic            memwe_m,
  input  logic            memre_m,
  input  logic [2:0]      funct3_m,
  output logic            stall_m,
  output logic            misalign_m,
  output logic [XLEN-1:0] load_data_m,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_t      state;
  logic            any_req;
  logic            is_half;
  logic            is_word;
  logic            misalign_raw;
  logic            acc;
  logic [XLEN-1:0] wdata_rep;
  logic [2:0]      lat_funct3;
  logic [1:0]      lat_off;
  logic [XLEN-1:0] ext_data;

  assign any_req      = memwe_m | memre_m;
  assign is_word      = funct3_m[1];
  assign is_half      = ~funct3_m[1] & funct3_m[0];
  assign misalign_raw = any_req & ((is_half & alu_out_m[0]) | (is_word & (|alu_out_m[1:0])));
  assign acc          = any_req & ~misalign_raw;

  // The pipeline is released in DONE so the next instruction arrives while we sit in IDLE.
  assign misalign_m = ~rst_in & misalign_raw;
  assign stall_m    = ~rst_in & acc & (state != DONE);

  // Replicate store data across every lane it may land in.
  always_comb begin
    wdata_rep = memwdata_m;
    case (funct3_m[1:0])
      2'b00:   wdata_rep = {4{memwdata_m[7:0]}};
      2'b01:   wdata_rep = {2{memwdata_m[15:0]}};
      default: wdata_rep = memwdata_m;
    endcase
  end

  lsu_load_ext u_load_ext (
    .rdata    (dmem_rdata),
    .funct3   (lat_funct3),
    .offset   (lat_off),
    .ext_data (ext_data)
  );

  // Access FSM; all bus fields are registered and frozen while a request is outstanding.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= 4'h0;
      dmem_wdata  <= '0;
      load_data_m <= '0;
      lat_funct3  <= F3_LB;
      lat_off     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            dmem_req   <= 1'b1;
            dmem_we    <= memwe_m;
            dmem_addr  <= {alu_out_m[XLEN-1:2], 2'b00};
            dmem_be    <= be_gen(funct3_m, alu_out_m[1:0]);
            dmem_wdata <= wdata_rep;
            lat_funct3 <= funct3_m;
            lat_off    <= alu_out_m[1:0];
            state      <= REQ;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            state    <= dmem_we ? DONE : RESP;
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            load_data_m <= ext_data;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu. The stimulus task drives the pipeline
// inputs and plays the bus responder, pushing expected bus requests and load
// results into queues; an independent monitor pops and compares them.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] alu_out_m;
  logic [31:0] memwdata_m;
  logic        memwe_m;
  logic        memre_m;
  logic [2:0]  funct3_m;
  logic        stall_m;
  logic        misalign_m;
  logic [31:0] load_data_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        checkWdata;
  } busExp_t;

  busExp_t     busQ[$];
  logic [31:0] loadQ[$];

  int compareCount  = 0;
  int mismatchCount = 0;

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .alu_out_m   (alu_out_m),
    .memwdata_m  (memwdata_m),
    .memwe_m     (memwe_m),
    .memre_m     (memre_m),
    .funct3_m    (funct3_m),
    .stall_m     (stall_m),
    .misalign_m  (misalign_m),
    .load_data_m (load_data_m),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ready  (dmem_ready),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  // 10-unit clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Monitor: compares bus handshakes and completed loads against the queues,
  // and checks that a waiting request holds all its fields.
  logic        holdValid   = 1'b0;
  logic [63:0] holdCtl;
  logic [31:0] holdWdata;
  logic        readPending = 1'b0;
  logic        loadNext    = 1'b0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      holdValid   = 1'b0;
      readPending = 1'b0;
      loadNext    = 1'b0;
    end else begin
      if (loadNext) begin
        loadNext = 1'b0;
        if (loadQ.size() == 0) checkOutput("load_unexpected", 64'd1, 64'd0);
        else checkOutput("load_data", {32'h0, load_data_m}, {32'h0, loadQ.pop_front()});
      end
      if (holdValid) begin
        checkOutput("bus_hold_ctl", {26'h0, dmem_req, dmem_we, dmem_be, dmem_addr}, holdCtl);
        checkOutput("bus_hold_wdata", {32'h0, dmem_wdata}, {32'h0, holdWdata});
        holdValid = 1'b0;
      end
      if (dmem_req && dmem_ready) begin
        if (busQ.size() == 0) begin
          checkOutput("bus_unexpected", 64'd1, 64'd0);
        end else begin
          busExp_t e;
          e = busQ.pop_front();
          checkOutput("bus_we", {63'h0, dmem_we}, {63'h0, e.we});
          checkOutput("bus_addr", {32'h0, dmem_addr}, {32'h0, e.addr});
          checkOutput("bus_be", {60'h0, dmem_be}, {60'h0, e.be});
          if (e.checkWdata) checkOutput("bus_wdata", {32'h0, dmem_wdata}, {32'h0, e.wdata});
        end
        if (!dmem_we) readPending = 1'b1;
      end else if (dmem_req) begin
        holdValid = 1'b1;
        holdCtl   = {26'h0, dmem_req, dmem_we, dmem_be, dmem_addr};
        holdWdata = dmem_wdata;
      end
      if (readPending && dmem_rvalid) begin
        readPending = 1'b0;
        loadNext    = 1'b1;
      end
    end
  end

  // One access: drive the M-stage inputs, act as the bus responder with the
  // given ready/rvalid delays, and count the cycles stall_m stays high.
  // Entered and left at posedge+1.
  task automatic applyStimulus(
    input string       name,
    input logic        we,
    input logic        re,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input int          readyDelay,
    input int          rvalidDelay,
    input logic [31:0] rdata,
    input logic [3:0]  expBe,
    input logic [31:0] expWdata,
    input logic [31:0] expLoad,
    input int          expStall,
    input logic        expMis
  );
    busExp_t e;
    int   stallCycles = 0;
    int   reqCycles   = 0;
    int   respCycles  = 0;
    logic inResp      = 1'b0;
    logic done        = 1'b0;
    memwe_m    = we;
    memre_m    = re;
    funct3_m   = f3;
    alu_out_m  = addr;
    memwdata_m = wd;
    dmem_rdata = rdata;
    if (!expMis) begin
      e.we         = we;
      e.addr       = {addr[31:2], 2'b00};
      e.be         = expBe;
      e.wdata      = expWdata;
      e.checkWdata = we;
      busQ.push_back(e);
      if (re) loadQ.push_back(expLoad);
    end
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ready = dmem_req && (reqCycles >= readyDelay);
      if (dmem_req) reqCycles++;
      dmem_rvalid = inResp && (respCycles >= rvalidDelay);
      if (inResp) respCycles++;
      @(negedge clk_in);
      if (c == 0) checkOutput({name, "_misalign"}, {63'h0, misalign_m}, {63'h0, expMis});
      if (stall_m) stallCycles++;
      else done = 1'b1;
      if (dmem_rvalid) inResp = 1'b0;
      else if (dmem_req && dmem_ready && !dmem_we) inResp = 1'b1;
      if (done && expMis) checkOutput({name, "_noreq"}, {63'h0, dmem_req}, 64'd0);
      @(posedge clk_in);
      #1;
    end
    if (!done) checkOutput({name, "_timeout"}, 64'd1, 64'd0);
    checkOutput({name, "_stall_cycles"}, 64'(stallCycles), 64'(expStall));
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    memwe_m     = 1'b0;
    memre_m     = 1'b0;
  endtask

  initial begin
    busExp_t e;
    rst_in      = 1'b1;
    memwe_m     = 1'b0;
    memre_m     = 1'b1;
    funct3_m    = F3_LH;
    alu_out_m   = 32'h0000_0101;
    memwdata_m  = 32'hFFFF_FFFF;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;

    // Reset state, with a misaligned load on the inputs to show forcing
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("rst_stall", {63'h0, stall_m}, 64'd0);
    checkOutput("rst_misalign", {63'h0, misalign_m}, 64'd0);
    checkOutput("rst_req", {63'h0, dmem_req}, 64'd0);
    checkOutput("rst_we", {63'h0, dmem_we}, 64'd0);
    checkOutput("rst_addr", {32'h0, dmem_addr}, 64'd0);
    checkOutput("rst_be", {60'h0, dmem_be}, 64'd0);
    checkOutput("rst_wdata", {32'h0, dmem_wdata}, 64'd0);
    checkOutput("rst_load", {32'h0, load_data_m}, 64'd0);
    @(posedge clk_in);
    #1;
    rst_in  = 1'b0;
    memre_m = 1'b0;

    // Stores: word, byte at top lane, half at upper lane
    applyStimulus("sw100", 1, 0, F3_LW, 32'h0000_0100, 32'h1234_5678, 0, 0, 32'h0,
                  4'hF, 32'h1234_5678, 32'h0, 2, 0);
    applyStimulus("sb203", 1, 0, F3_LB, 32'h0000_0203, 32'h1234_56A5, 0, 0, 32'h0,
                  4'b1000, 32'hA5A5_A5A5, 32'h0, 2, 0);
    applyStimulus("sh102", 1, 0, F3_LH, 32'h0000_0102, 32'h1234_BEEF, 1, 0, 32'h0,
                  4'b1100, 32'hBEEF_BEEF, 32'h0, 3, 0);

    // Loads: sign and zero extension on different lanes
    applyStimulus("lb102", 0, 1, F3_LB, 32'h0000_0102, 32'h0, 0, 0, 32'h0080_0000,
                  4'b0100, 32'h0, 32'hFFFF_FF80, 3, 0);
    applyStimulus("lbu102", 0, 1, F3_LBU, 32'h0000_0102, 32'h0, 0, 0, 32'h0080_0000,
                  4'b0100, 32'h0, 32'h0000_0080, 3, 0);
    applyStimulus("lhu102", 0, 1, F3_LHU, 32'h0000_0102, 32'h0, 0, 0, 32'hBEEF_0000,
                  4'b1100, 32'h0, 32'h0000_BEEF, 3, 0);
    applyStimulus("lh102", 0, 1, F3_LH, 32'h0000_0102, 32'h0, 0, 1, 32'h8001_0000,
                  4'b1100, 32'h0, 32'hFFFF_8001, 4, 0);
    applyStimulus("lb101", 0, 1, F3_LB, 32'h0000_0101, 32'h0, 0, 0, 32'h0000_7F00,
                  4'b0010, 32'h0, 32'h0000_007F, 3, 0);

    // Slow bus: ready low for 3 REQ cycles, rvalid 2 cycles into RESP
    applyStimulus("lw104", 0, 1, F3_LW, 32'h0000_0104, 32'h0, 3, 2, 32'hCAFE_F00D,
                  4'hF, 32'h0, 32'hCAFE_F00D, 8, 0);

    // Misaligned accesses are suppressed without stalling
    applyStimulus("lh101", 0, 1, F3_LH, 32'h0000_0101, 32'h0, 0, 0, 32'h0,
                  4'h0, 32'h0, 32'h0, 0, 1);
    applyStimulus("sw102", 1, 0, F3_LW, 32'h0000_0102, 32'h5555_AAAA, 0, 0, 32'h0,
                  4'h0, 32'h0, 32'h0, 0, 1);
    applyStimulus("f3_011", 0, 1, 3'b011, 32'h0000_0102, 32'h0, 0, 0, 32'h0,
                  4'h0, 32'h0, 32'h0, 0, 1);
    checkOutput("load_kept_after_store_misalign", {32'h0, load_data_m}, {32'h0, 32'hCAFE_F00D});

    // Reset while in RESP abandons the load; a late rvalid is ignored
    memre_m   = 1'b1;
    funct3_m  = F3_LW;
    alu_out_m = 32'h0000_0108;
    e.we = 1'b0; e.addr = 32'h0000_0108; e.be = 4'hF; e.wdata = 32'h0; e.checkWdata = 1'b0;
    busQ.push_back(e);
    @(posedge clk_in);
    #1;
    dmem_ready = 1'b1;
    @(posedge clk_in);
    #1;
    dmem_ready = 1'b0;
    rst_in     = 1'b1;
    @(negedge clk_in);
    checkOutput("rstmid_stall_forced", {63'h0, stall_m}, 64'd0);
    @(posedge clk_in);
    #1;
    rst_in      = 1'b0;
    memre_m     = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk_in);
    checkOutput("rstmid_req", {63'h0, dmem_req}, 64'd0);
    checkOutput("rstmid_load", {32'h0, load_data_m}, 64'd0);
    checkOutput("rstmid_stall", {63'h0, stall_m}, 64'd0);
    @(posedge clk_in);
    #1;
    dmem_rvalid = 1'b0;
    @(negedge clk_in);
    checkOutput("late_rvalid_load", {32'h0, load_data_m}, 64'd0);
    checkOutput("late_rvalid_req", {63'h0, dmem_req}, 64'd0);
    @(posedge clk_in);
    #1;

    // Normal operation resumes after the abandoned access
    applyStimulus("lw10c", 0, 1, F3_LW, 32'h0000_010C, 32'h0, 0, 0, 32'h0BAD_F00D,
                  4'hF, 32'h0, 32'h0BAD_F00D, 3, 0);

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("busq_drained", 64'(busQ.size()), 64'd0);
    checkOutput("loadq_drained", 64'(loadQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
